eth_rst_seq: RTL and testbench

//  Power-up reset sequencer for the Nios II Ethernet system. It sits upstream of the

---
 rtl/eth_rst_seq.sv | 69 ++++++
 tb/tb_eth_rst_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/eth_rst_seq.sv
// eth_rst_seq: power-up reset sequencer for PLL lock, PHY reset pulse, PHY settle and Nios II release
module eth_rst_seq #(
  parameter int LOCK_FILT      = 16,
  parameter int PHY_RST_CYC    = 500000,
  parameter int PHY_SETTLE_CYC = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pll_locked,
  input  logic soft_rst_req,
  output logic eth_rst_n,
  output logic nios_rst_n,
  output logic phy_ready
);
  localparam int MAXC = (PHY_RST_CYC > PHY_SETTLE_CYC) ? PHY_RST_CYC : PHY_SETTLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int LW   = $clog2(LOCK_FILT + 1);
  typedef enum logic [1:0] {IDLE, PHY_RST, PHY_WAIT, RUN} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] lk_sr, rq_sr;
  logic [LW-1:0] lf_cnt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic lk_s, rq_s, rq_d, rq_rise, lock_ok;
  assign lk_s    = lk_sr[SYNC_STAGES-1];
  assign rq_s    = rq_sr[SYNC_STAGES-1];
  assign rq_rise = rq_s & ~rq_d;
  assign lock_ok = lf_cnt == LW'(LOCK_FILT);
  // synchronizers, request edge history and saturating lock filter
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      lk_sr  <= '0;
      rq_sr  <= '0;
      rq_d   <= 1'b0;
      lf_cnt <= '0;
    end else begin
      lk_sr  <= {lk_sr[SYNC_STAGES-2:0], pll_locked};
      rq_sr  <= {rq_sr[SYNC_STAGES-2:0], soft_rst_req};
      rq_d   <= rq_s;
      lf_cnt <= !lk_s ? '0 : lock_ok ? lf_cnt : lf_cnt + 1'b1;
    end
  // next state; lock loss overrides everything, request edges only matter in RUN
  always_comb begin
    nxt = state;
    if (!lk_s) nxt = IDLE;
    else case (state)
      IDLE:     nxt = lock_ok ? PHY_RST : IDLE;
      PHY_RST:  nxt = (cnt == CW'(PHY_RST_CYC - 1)) ? PHY_WAIT : PHY_RST;
      PHY_WAIT: nxt = (cnt == CW'(PHY_SETTLE_CYC - 1)) ? RUN : PHY_WAIT;
      default:  nxt = rq_rise ? PHY_RST : RUN;
    endcase
    cnt_nxt = (nxt != state || state == IDLE || state == RUN) ? '0 : cnt + 1'b1;
  end
  // state, counter and outputs decoded from next state so they move together
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      eth_rst_n  <= 1'b0;
      nios_rst_n <= 1'b0;
      phy_ready  <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      eth_rst_n  <= nxt == PHY_WAIT || nxt == RUN;
      nios_rst_n <= nxt == RUN ? 1'b1 : nxt == IDLE ? 1'b0 : nios_rst_n;
      phy_ready  <= nxt == RUN;
    end
endmodule

// File: tb/tb_eth_rst_seq.sv
// tb_eth_rst_seq: scoreboard bench for eth_rst_seq with short timing parameters
module tb_eth_rst_seq;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic soft_rst_req = 1'b0;
  logic eth_rst_n, nios_rst_n, phy_ready;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  eth_rst_seq #(.LOCK_FILT(4), .PHY_RST_CYC(10), .PHY_SETTLE_CYC(5), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req), .eth_rst_n(eth_rst_n), .nios_rst_n(nios_rst_n),
    .phy_ready(phy_ready)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // from a release or relock edge: 2 sync + 4 filter + 1 -> PHY_RST at 7, eth up at 17, nios up at 22
  task automatic run_seq(input int soft_at, input string tag);
    int t_eth, t_nios, e;
    logic pe;
    exp_q.push_back(17);
    exp_q.push_back(22);
    t_eth = -1;
    t_nios = -1;
    pe = eth_rst_n;
    for (int n = 1; n <= 40 && t_nios < 0; n++) begin
      tick();
      if (n == soft_at) soft_rst_req = 1'b1;
      if (eth_rst_n && !pe && t_eth < 0) t_eth = n;
      if (nios_rst_n && t_nios < 0) t_nios = n;
      pe = eth_rst_n;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (t_eth !== e) begin n_err++; $display("FAIL %s eth_rise: got %0d want %0d", tag, t_eth, e); end
    e = exp_q.pop_front();
    n_cmp++;
    if (t_nios !== e) begin n_err++; $display("FAIL %s nios_rise: got %0d want %0d", tag, t_nios, e); end
    n_cmp++;
    if (phy_ready !== 1'b1) begin n_err++; $display("FAIL %s phy_ready: got %b want 1", tag, phy_ready); end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pll_locked = 1'b1;
    soft_rst_req = 1'b0;
    #20;
    n_cmp++;
    if ({eth_rst_n, nios_rst_n, phy_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_outs: got %b want 000", {eth_rst_n, nios_rst_n, phy_ready});
    end
    tick();
    sys_rst_n = 1'b1;
    run_seq(-1, "powerup");
  endtask

  task automatic test_soft();
    int lo_eth, lo_rdy, falls, nios_lo, e;
    logic pe;
    exp_q.push_back(10);
    exp_q.push_back(15);
    lo_eth = 0; lo_rdy = 0; falls = 0; nios_lo = 0;
    pe = eth_rst_n;
    soft_rst_req = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n == 50) soft_rst_req = 1'b0;
      if (!eth_rst_n) lo_eth++;
      if (!phy_ready) lo_rdy++;
      if (!nios_rst_n) nios_lo++;
      if (pe && !eth_rst_n) falls++;
      pe = eth_rst_n;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (lo_eth !== e) begin n_err++; $display("FAIL soft_eth_low: got %0d want %0d", lo_eth, e); end
    e = exp_q.pop_front();
    n_cmp++;
    if (lo_rdy !== e) begin n_err++; $display("FAIL soft_rdy_low: got %0d want %0d", lo_rdy, e); end
    n_cmp++;
    if (falls !== 1) begin n_err++; $display("FAIL soft_pulses: got %0d want 1", falls); end
    n_cmp++;
    if (nios_lo !== 0) begin n_err++; $display("FAIL soft_nios_low: got %0d want 0", nios_lo); end
  endtask

  task automatic test_sys_reset();
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({eth_rst_n, nios_rst_n, phy_ready} !== 3'b000) begin
      n_err++; $display("FAIL async_reset: got %b want 000", {eth_rst_n, nios_rst_n, phy_ready});
    end
    #20;
    tick();
    sys_rst_n = 1'b1;
    run_seq(-1, "rerelease");
  endtask

  task automatic test_lock_glitch();
    int bad;
    sys_rst_n = 1'b0;
    pll_locked = 1'b0;
    #20;
    tick();
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      pll_locked = (i % 4) != 3;
      tick();
      if ({eth_rst_n, nios_rst_n, phy_ready} !== 3'b000) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL glitch_idle: got %0d active cycles want 0", bad); end
    pll_locked = 1'b0;
    tick();
  endtask

  task automatic test_lock_loss();
    sys_rst_n = 1'b0;
    pll_locked = 1'b1;
    #20;
    tick();
    sys_rst_n = 1'b1;
    repeat (19) tick();
    n_cmp++;
    if ({eth_rst_n, nios_rst_n} !== 2'b10) begin
      n_err++; $display("FAIL in_phy_wait: got %b want 10", {eth_rst_n, nios_rst_n});
    end
    pll_locked = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({eth_rst_n, nios_rst_n, phy_ready} !== 3'b000) begin
      n_err++; $display("FAIL lock_loss: got %b want 000", {eth_rst_n, nios_rst_n, phy_ready});
    end
    pll_locked = 1'b1;
    run_seq(-1, "relock");
  endtask

  task automatic test_soft_ignored();
    int lo;
    sys_rst_n = 1'b0;
    soft_rst_req = 1'b0;
    #20;
    tick();
    sys_rst_n = 1'b1;
    run_seq(10, "soft_in_phy_rst");
    lo = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (!eth_rst_n || !phy_ready) lo++;
    end
    n_cmp++;
    if (lo !== 0) begin n_err++; $display("FAIL soft_not_queued: got %0d low cycles want 0", lo); end
    soft_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_soft();
    test_sys_reset();
    test_lock_glitch();
    test_lock_loss();
    test_soft_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
